// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe turn controller: cell/board encoding,
// winner codes and controller states.
package ttt_pkg;

   typedef logic [1:0] cell_t;
   localparam cell_t CELL_EMPTY = 2'b11;

   // board[y][x]; cell (y,x) lands at flat bits [(y*3+x)*2 +: 2]
   typedef cell_t [2:0][2:0] board_t;
   localparam board_t BOARD_EMPTY = '1;

   localparam logic [1:0] WIN_P0   = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_DRAW = 2'd2;
   localparam logic [1:0] WIN_NONE = 2'd3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_TURN  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_TURN  = S_TURN,
      ST_CHECK = S_CHECK,
      ST_OVER  = S_OVER
   } ctrl_state_t;

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: win is high when any row, column or diagonal
// is fully owned by the given player.
import ttt_pkg::*;

module ttt_win_check (
   input  board_t board,
   input  logic   player,
   output logic   win
);

   cell_t      p;
   logic [2:0] row_hit;
   logic [2:0] col_hit;
   logic [1:0] diag_hit;

   assign p = {1'b0, player};

   // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         row_hit[i] = (board[i][0] == p) && (board[i][1] == p) && (board[i][2] == p);
         col_hit[i] = (board[0][i] == p) && (board[1][i] == p) && (board[2][i] == p);
      end
      diag_hit[0] = (board[0][0] == p) && (board[1][1] == p) && (board[2][2] == p);
      diag_hit[1] = (board[0][2] == p) && (board[1][1] == p) && (board[2][0] == p);
      win = (|row_hit) | (|col_hit) | (|diag_hit);
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Turn scheduler and referee: grants the player on turn, validates and applies
// moves, and ends the game on a win, a full board or a turn timeout.
import ttt_pkg::*;

module ttt_game_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int STARTER        = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_x0,
   input  logic [1:0]  req_y0,
   input  logic [1:0]  req_x1,
   input  logic [1:0]  req_y1,
   output logic [1:0]  req_ready,
   output logic        rsp_valid,
   output logic        rsp_ok,
   output logic [17:0] board,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic        timeout
);

   localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   ctrl_state_t   state;
   board_t        board_q;
   logic [3:0]    move_cnt;
   logic [TW-1:0] timer;

   logic [1:0] mx, my;
   logic       handshake;
   logic       legal;
   logic       win;

   always_comb begin
      mx        = turn ? req_x1 : req_x0;
      my        = turn ? req_y1 : req_y0;
      handshake = (state == ST_TURN) && req_valid[turn];
      legal     = handshake && (mx < 2'd3) && (my < 2'd3)
                  && (board_q[my][mx] == CELL_EMPTY);
   end

   assign req_ready = (state == ST_TURN) ? (turn ? 2'b10 : 2'b01) : 2'b00;
   assign board     = board_q;
   assign game_over = (state == ST_OVER);

   // CHECK judges the player who just moved, before turn toggles
   ttt_win_check u_win_check (
      .board  (board_q),
      .player (turn),
      .win    (win)
   );

   // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         board_q   <= BOARD_EMPTY;
         move_cnt  <= '0;
         timer     <= '0;
         turn      <= 1'(STARTER);
         winner    <= WIN_NONE;
         timeout   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_ok    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_ok    <= 1'b0;
         case (state)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  board_q  <= BOARD_EMPTY;
                  move_cnt <= '0;
                  timer    <= '0;
                  winner   <= WIN_NONE;
                  timeout  <= 1'b0;
                  turn     <= 1'(STARTER);
                  state    <= ST_TURN;
               end
            end
            ST_TURN: begin
               if (handshake) begin
                  // an illegal request is answered but neither ages the timer nor forfeits
                  rsp_valid <= 1'b1;
                  rsp_ok    <= legal;
                  if (legal) begin
                     board_q[my][mx] <= {1'b0, turn};
                     if (move_cnt != 4'd9) move_cnt <= move_cnt + 4'd1;
                     state <= ST_CHECK;
                  end
               end else if (timer == TIMER_LAST) begin
                  winner  <= {1'b0, ~turn};
                  timeout <= 1'b1;
                  state   <= ST_OVER;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_CHECK: begin
               if (win) begin
                  winner <= {1'b0, turn};
                  state  <= ST_OVER;
               end else if (move_cnt == 4'd9) begin
                  winner <= WIN_DRAW;
                  state  <= ST_OVER;
               end else begin
                  turn  <= ~turn;
                  timer <= '0;
                  state <= ST_TURN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed games plus random play,
// compared against a cell-array game model and a response scoreboard.
module tb_ttt_game_ctrl;

   localparam int TO      = 8;
   localparam int STARTER = 0;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  req_valid, req_x0, req_y0, req_x1, req_y1;
   logic [1:0]  req_ready;
   logic        rsp_valid, rsp_ok;
   logic [17:0] board;
   logic        turn, game_over, timeout;
   logic [1:0]  winner;

   ttt_game_ctrl #(.TIMEOUT_CYCLES(TO), .STARTER(STARTER)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .req_valid (req_valid),
      .req_x0    (req_x0),
      .req_y0    (req_y0),
      .req_x1    (req_x1),
      .req_y1    (req_y1),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ok    (rsp_ok),
      .board     (board),
      .turn      (turn),
      .game_over (game_over),
      .winner    (winner),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: nine cells, -1 empty, else owning player
   int m_cell[9];
   int m_turn, m_moves, m_idle, m_winner;
   bit m_timeout, m_play, m_judge, m_over;

   typedef struct {
      int due;
      bit ok;
   } rsp_t;
   rsp_t q[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [17:0] board_bits();
      logic [17:0] b = '1;
      for (int k = 0; k < 9; k++)
         if (m_cell[k] >= 0) b[k*2 +: 2] = 2'(m_cell[k]);
      return b;
   endfunction

   function automatic bit has_line(input int p);
      int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      for (int l = 0; l < 8; l++)
         if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_new_game();
      for (int k = 0; k < 9; k++) m_cell[k] = -1;
      m_turn = STARTER; m_moves = 0; m_idle = 0;
      m_winner = 3; m_timeout = 1'b0;
   endtask

   // One clock: compare outputs, drive inputs, advance the model
   task automatic step(input bit rst, input bit st, input logic [1:0] v,
                       input int x0, input int y0, input int x1, input int y1);
      int x, y;
      bit ok;
      @(negedge clk);
      check("req_ready", req_ready, m_play ? (m_turn ? 2 : 1) : 0);
      check("status", {game_over, winner, timeout, turn},
            {m_over, 2'(m_winner), m_timeout, 1'(m_turn)});
      check("board", board, board_bits());
      reset = rst; start = st; req_valid = v;
      req_x0 = 2'(x0); req_y0 = 2'(y0); req_x1 = 2'(x1); req_y1 = 2'(y1);
      if (rst) begin
         model_new_game();
         m_play = 0; m_judge = 0; m_over = 0;
      end else if (m_judge) begin
         m_judge = 0;
         if (has_line(m_turn)) begin
            m_over = 1; m_winner = m_turn;
         end else if (m_moves == 9) begin
            m_over = 1; m_winner = 2;
         end else begin
            m_turn = 1 - m_turn; m_idle = 0; m_play = 1;
         end
      end else if (m_play) begin
         x = m_turn ? x1 : x0;
         y = m_turn ? y1 : y0;
         if (v[m_turn]) begin
            ok = (x < 3) && (y < 3) && (m_cell[y*3+x] < 0);
            q.push_back('{cyc + 1, ok});
            if (ok) begin
               m_cell[y*3+x] = m_turn; m_moves++;
               m_play = 0; m_judge = 1;
            end
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_play = 0; m_over = 1; m_winner = 1 - m_turn; m_timeout = 1;
            end
         end
      end else if (st) begin
         model_new_game();
         m_play = 1; m_over = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   // Move plus the following CHECK cycle
   task automatic mv(input int p, input int x, input int y);
      if (p == 0) step(0, 0, 2'b01, x, y, 0, 0);
      else        step(0, 0, 2'b10, 0, 0, x, y);
      idle(1);
   endtask

   // Response monitor: pops the scoreboard whenever the DUT answers
   always @(negedge clk) begin
      rsp_t r;
      if (rsp_valid) begin
         if (q.size() == 0) begin
            check("rsp_spurious", rsp_valid, 0);
         end else begin
            r = q.pop_front();
            check("rsp_cycle", cyc, r.due);
            check("rsp_ok", rsp_ok, r.ok);
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         r = q.pop_front();
         check("rsp_missing", rsp_valid, 1);
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; req_valid = 2'b00;
      req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
      model_new_game();
      m_play = 0; m_judge = 0; m_over = 0;
      repeat (2) @(posedge clk);
      step(1, 0, 2'b00, 0, 0, 0, 0);
      idle(1);
      check("reset_board", board, 18'h3ffff);
      check("reset_winner", winner, 3);

      // Diagonal win for P0
      step(0, 1, 2'b00, 0, 0, 0, 0);
      idle(1);
      mv(0, 0, 0); mv(1, 0, 1); mv(0, 1, 1); mv(1, 0, 2); mv(0, 2, 2);
      idle(1);
      check("win_over", game_over, 1);
      check("win_winner", winner, 0);
      check("win_timeout", timeout, 0);

      // Out-of-turn, out-of-range and occupied-cell requests
      step(0, 1, 2'b00, 0, 0, 0, 0);
      step(0, 0, 2'b10, 0, 0, 1, 1);
      check("oot_ready1", req_ready[1], 0);
      step(0, 0, 2'b01, 3, 0, 0, 0);
      idle(1);
      check("illegal_turn", turn, 0);
      mv(0, 1, 1); mv(1, 0, 0);
      step(0, 0, 2'b01, 1, 1, 0, 0);
      idle(1);
      check("occupied_cell", board[(1*3+1)*2 +: 2], 0);

      // Draw: full board without a line
      step(1, 0, 2'b00, 0, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0, 0);
      mv(0, 0, 0); mv(1, 1, 0); mv(0, 2, 0); mv(1, 1, 1); mv(0, 0, 1);
      mv(1, 2, 1); mv(0, 1, 2); mv(1, 0, 2); mv(0, 2, 2);
      idle(1);
      check("draw_over", game_over, 1);
      check("draw_winner", winner, 2);

      // Timeout on P1's turn
      step(0, 1, 2'b00, 0, 0, 0, 0);
      mv(0, 0, 0);
      idle(TO + 2);
      check("to_over", game_over, 1);
      check("to_winner", winner, 0);
      check("to_flag", timeout, 1);

      // Simultaneous valids: only the turn player is served
      step(0, 1, 2'b00, 0, 0, 0, 0);
      step(0, 0, 2'b11, 0, 0, 1, 1);
      step(0, 0, 2'b11, 0, 0, 1, 1);
      step(0, 0, 2'b11, 0, 0, 1, 1);
      idle(2);
      check("sim_p1_cell", board[(1*3+1)*2 +: 2], 1);

      // Reset mid-game, restart, and a start ignored during TURN
      mv(0, 2, 0);
      step(1, 0, 2'b00, 0, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0, 0);
      idle(1);
      check("rst_board", board, 18'h3ffff);
      check("rst_turn", turn, STARTER);
      check("rst_winner", winner, 3);

      // Random play
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
              2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end
      idle(3);
      check("queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
